div_seq: RTL and testbench

Multi-cycle signed/unsigned divider sequencer for the execute stage of the pipelined MIPS core. It accepts a DIV/DIVU issued in execute, holds the pipeline with a stall while it runs a radix-2 restoring shift-subtract over WIDTH iterations, and delivers quotient (LO) and remainder (HI) for the HI/LO write. Sits beside the ALU and is driven by the decoded `divE`/`hassignE` controls and the hazard unit's flush.

---
 rtl/div_seq_pkg.sv | 16 +
 rtl/div_step.sv | 32 +++
 rtl/div_seq.sv | 118 +++++++++++
 tb/tb_div_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the execute-stage divider sequencer: FSM state
// encoding and the fixed divide-by-zero quotient.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient returned for any divide by zero (all ones, like MIPS hardware).
    localparam logic [DIV_WIDTH-1:0] DIVZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration of the divider.
// Purely combinational; div_seq applies it once per BUSY cycle.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem stays below the divisor, so the shifted value is below 2*divisor and
    // the top bit of a WIDTH+1-bit difference is a reliable borrow flag.
    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o  = trial[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = shifted[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside the ALU: stalls the pipeline while it
// iterates and delivers quotient (LO) and remainder (HI) with a one-cycle ready.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] div_q;
    logic             qs_q;
    logic             rs_q;
    logic             ready_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;
    logic             accept;
    logic             a_neg;
    logic             b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (div_q),
        .rem_o     (rem_d),
        .quot_o    (quot_d)
    );

    assign accept = (state_q == IDLE) && start_i && !annul_i;
    assign a_neg  = signed_i && a_i[WIDTH-1];
    assign b_neg  = signed_i && b_i[WIDTH-1];

    // Stall drops in DONE so the pipeline advances exactly once with the result.
    assign stall_o = accept || (state_q == BUSY);
    assign ready_o = ready_q;
    assign lo_o    = lo_q;
    assign hi_o    = hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (b_i == '0) begin
                            lo_q    <= {WIDTH{DIVZERO_Q[0]}};
                            hi_q    <= a_i;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Iterate on magnitudes; signs are reapplied on exit.
                            quot_q  <= a_neg ? -a_i : a_i;
                            div_q   <= b_neg ? -b_i : b_i;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qs_q    <= a_neg ^ b_neg;
                            rs_q    <= a_neg;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            lo_q    <= qs_q ? -quot_d : quot_d;
                            hi_q    <= rs_q ? -rem_d : rem_d;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random DIV/DIVU traffic
// compared against a plain-arithmetic reference computed in 64-bit integers.
module tb_div_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             isSigned;
    logic             annul;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             stall;
    logic             ready;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;
    int lastReadyCycle = 0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .signed_i (isSigned),
        .annul_i  (annul),
        .a_i      (aIn),
        .b_i      (bIn),
        .stall_o  (stall),
        .ready_o  (ready),
        .lo_o     (lo),
        .hi_o     (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: DIVU is plain unsigned arithmetic; DIV is truncating signed
    // division done in 64 bits so the most-negative / -1 case cannot overflow.
    task automatic refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sgn, output logic [WIDTH-1:0] q,
                          output logic [WIDTH-1:0] r);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[WIDTH-1:0];
            r  = sr[WIDTH-1:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide at the current cycle T and checks latency, stall length,
    // results and that ready is a single-cycle pulse.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sgn);
        logic [WIDTH-1:0] expLo, expHi;
        int expLat, cyc, stallCnt;
        refDiv(a, b, sgn, expLo, expHi);
        expLat   = (b == '0) ? 1 : WIDTH + 1;
        start    = 1'b1;
        isSigned = sgn;
        aIn      = a;
        bIn      = b;
        #1;
        stallCnt = stall ? 1 : 0;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!ready && cyc < 3 * WIDTH) begin
            if (stall) stallCnt++;
            tick();
            cyc++;
        end
        lastReadyCycle = cycleNum;
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, ".stallCycles"}, 64'(stallCnt), 64'(expLat));
        checkOutput({tag, ".stallInDone"}, 64'(stall), 64'd0);
        checkOutput({tag, ".lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, ".hi"}, 64'(hi), 64'(expHi));
        tick();
        checkOutput({tag, ".readyPulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] savedLo, savedHi, ra, rb;
        int r1, readySeen;
        rst = 1'b1; start = 1'b0; isSigned = 1'b0; annul = 1'b0; aIn = '0; bIn = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset.ready", 64'(ready), 64'd0);
        checkOutput("reset.stall", 64'(stall), 64'd0);
        checkOutput("reset.lo", 64'(lo), 64'd0);
        checkOutput("reset.hi", 64'(hi), 64'd0);
        tick();

        applyStimulus("divu100_7", 32'd100, 32'd7, 1'b0);
        applyStimulus("divNeg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus("div7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        applyStimulus("divOverflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("divu5_0", 32'd5, 32'd0, 1'b0);
        applyStimulus("divSignedZero", 32'hFFFF_FF00, 32'd0, 1'b1);

        // Annul a running DIVU 50/3 at T+10: results must not move, no ready.
        savedLo = lo;
        savedHi = hi;
        start = 1'b1; isSigned = 1'b0; aIn = 32'd50; bIn = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        #1;
        checkOutput("annul.stall", 64'(stall), 64'd0);
        readySeen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (ready) readySeen++;
            tick();
        end
        checkOutput("annul.noReady", 64'(readySeen), 64'd0);
        checkOutput("annul.loKept", 64'(lo), 64'(savedLo));
        checkOutput("annul.hiKept", 64'(hi), 64'(savedHi));
        applyStimulus("afterAnnul9_4", 32'd9, 32'd4, 1'b0);

        // Start and annul together in IDLE: annul wins.
        start = 1'b1; annul = 1'b1; aIn = 32'd77; bIn = 32'd5;
        #1;
        checkOutput("startAnnul.stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0; annul = 1'b0;
        readySeen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (ready || stall) readySeen++;
            tick();
        end
        checkOutput("startAnnul.idle", 64'(readySeen), 64'd0);

        // Synchronous reset mid-divide clears results with no ready pulse.
        start = 1'b1; isSigned = 1'b0; aIn = 32'd100; bIn = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midReset.stall", 64'(stall), 64'd0);
        checkOutput("midReset.ready", 64'(ready), 64'd0);
        checkOutput("midReset.lo", 64'(lo), 64'd0);
        checkOutput("midReset.hi", 64'(hi), 64'd0);
        readySeen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (ready) readySeen++;
            tick();
        end
        checkOutput("midReset.noReady", 64'(readySeen), 64'd0);

        // Back-to-back: second request the cycle after DONE.
        applyStimulus("b2bFirst", 32'd10, 32'd3, 1'b0);
        r1 = lastReadyCycle;
        applyStimulus("b2bSecond", 32'd20, 32'd6, 1'b0);
        checkOutput("b2b.gap", 64'(lastReadyCycle - r1), 64'(WIDTH + 2));

        // Random traffic with a mix of divisor shapes.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = (n % 2 == 0) ? 32'd0 : 32'd1;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            applyStimulus($sformatf("rand%0d", n), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
